// File: rtl/qpsk_symbol_mod_pkg.sv
// Shared types and constants for the QPSK symbol modulator slice.
package qpsk_pkg;

    // Bit collector states: gather I, gather Q, then hold the dibit until a boundary.
    typedef enum logic [1:0] {
        COLLECT_I = 2'd0,
        COLLECT_Q = 2'd1,
        HOLD      = 2'd2
    } coll_state_t;

    // Default build-time geometry.
    localparam int DEF_DW  = 8;
    localparam int DEF_SPS = 30;
    localparam int DEF_CW  = 8;

    // Data bit to carrier sign mapping: 0 -> +1, 1 -> -1.
    localparam logic BIT_POS = 1'b0;
    localparam logic BIT_NEG = 1'b1;

endpackage : qpsk_pkg

// File: rtl/qpsk_symbol_mod_if.sv
// Sample/bit/output bundle between the carrier source, bit source and the modulator.
interface qpsk_symbol_mod_if #(
    parameter int DW = 8
);
    logic                 smp_valid;
    logic signed [DW-1:0] sin_in;
    logic signed [DW-1:0] cos_in;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic                 out_valid;
    logic signed [DW+1:0] data_out;
    logic                 sym_active;
    logic                 underrun;

    // Producer side: drives samples and bits, observes the modulated output.
    modport master (
        output smp_valid, sin_in, cos_in, bit_in, bit_valid,
        input  bit_ready, out_valid, data_out, sym_active, underrun
    );

    // Modulator side.
    modport slave (
        input  smp_valid, sin_in, cos_in, bit_in, bit_valid,
        output bit_ready, out_valid, data_out, sym_active, underrun
    );
endinterface : qpsk_symbol_mod_if

// File: rtl/qpsk_symbol_mod_dibit_collector.sv
// Serial-to-dibit collector: accepts an I bit then a Q bit, then holds the
// pair (and stalls the bit source) until a symbol boundary consumes it.
module dibit_collector
    import qpsk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic consume,
    output logic bit_ready,
    output logic hold,
    output logic dibit_i,
    output logic dibit_q
);

    coll_state_t state_r;
    logic        ready_r;
    logic        i_r;
    logic        q_r;
    logic        xfer_s;

    assign xfer_s    = bit_valid & ready_r;
    assign bit_ready = ready_r;
    assign hold      = (state_r == HOLD);
    assign dibit_i   = i_r;
    assign dibit_q   = q_r;

    // Collector FSM; bit_ready is registered alongside the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= COLLECT_I;
            ready_r <= 1'b1;
            i_r     <= 1'b0;
            q_r     <= 1'b0;
        end else begin
            case (state_r)
                COLLECT_I: begin
                    if (xfer_s) begin
                        i_r     <= bit_in;
                        state_r <= COLLECT_Q;
                    end
                end
                COLLECT_Q: begin
                    if (xfer_s) begin
                        q_r     <= bit_in;
                        state_r <= HOLD;
                        ready_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        state_r <= COLLECT_I;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= COLLECT_I;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule : dibit_collector

// File: rtl/qpsk_symbol_mod.sv
// QPSK passband modulator: out = I*cos + Q*sin per carrier sample, with a new
// symbol (or an idle/underrun period) every SPS samples.
module qpsk_symbol_mod
    import qpsk_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int SPS = DEF_SPS,
    parameter int CW  = DEF_CW
) (
    input  logic                clk,
    input  logic                rst_n,
    qpsk_symbol_mod_if.slave    bus
);

    localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0]        cnt_r;
    logic                 act_r;
    logic                 act_i_r;
    logic                 act_q_r;
    logic signed [DW+1:0] data_out_r;
    logic                 out_valid_r;
    logic                 underrun_r;

    logic                 boundary_s;
    logic                 consume_s;
    logic                 hold_s;
    logic                 dibit_i_s;
    logic                 dibit_q_s;
    logic                 use_act_s;
    logic                 use_i_s;
    logic                 use_q_s;
    logic signed [DW+1:0] cos_ext_s;
    logic signed [DW+1:0] sin_ext_s;
    logic signed [DW+1:0] ci_s;
    logic signed [DW+1:0] sq_s;
    logic signed [DW+1:0] mod_s;

    dibit_collector u_collector (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bus.bit_in),
        .bit_valid (bus.bit_valid),
        .consume   (consume_s),
        .bit_ready (bus.bit_ready),
        .hold      (hold_s),
        .dibit_i   (dibit_i_s),
        .dibit_q   (dibit_q_s)
    );

    // A boundary is the first sample of each SPS-sample symbol period.
    assign boundary_s = bus.smp_valid && (cnt_r == CNT_ZERO);
    assign consume_s  = boundary_s && hold_s;

    // Select the symbol for this sample: the boundary sample already uses the newly loaded one.
    always_comb begin
        use_act_s = act_r;
        use_i_s   = act_i_r;
        use_q_s   = act_q_r;
        if (boundary_s) begin
            if (hold_s) begin
                use_act_s = 1'b1;
                use_i_s   = dibit_i_s;
                use_q_s   = dibit_q_s;
            end else begin
                use_act_s = 1'b0;
            end
        end else begin
            use_act_s = act_r;
        end
    end

    // Sign-extend by two bits first so that negating -2^(DW-1) and summing cannot wrap.
    always_comb begin
        cos_ext_s = {{2{bus.cos_in[DW-1]}}, bus.cos_in};
        sin_ext_s = {{2{bus.sin_in[DW-1]}}, bus.sin_in};
        if (use_i_s == BIT_NEG) begin
            ci_s = -cos_ext_s;
        end else begin
            ci_s = cos_ext_s;
        end
        if (use_q_s == BIT_NEG) begin
            sq_s = -sin_ext_s;
        end else begin
            sq_s = sin_ext_s;
        end
        if (use_act_s) begin
            mod_s = ci_s + sq_s;
        end else begin
            mod_s = {(DW+2){1'b0}};
        end
    end

    // Sample counter, wrapping after SPS samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (bus.smp_valid) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Active-symbol register; only changes at a boundary since use_* mirror it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r   <= 1'b0;
            act_i_r <= 1'b0;
            act_q_r <= 1'b0;
        end else if (bus.smp_valid) begin
            act_r   <= use_act_s;
            act_i_r <= use_i_s;
            act_q_r <= use_q_s;
        end else begin
            act_r   <= act_r;
            act_i_r <= act_i_r;
            act_q_r <= act_q_r;
        end
    end

    // Output registers: data holds between samples, valid/underrun are per-sample pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r  <= {(DW+2){1'b0}};
            out_valid_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            out_valid_r <= bus.smp_valid;
            underrun_r  <= boundary_s && !hold_s;
            if (bus.smp_valid) begin
                data_out_r <= mod_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.sym_active = act_r;
    assign bus.underrun   = underrun_r;

endmodule : qpsk_symbol_mod

// File: tb/tb_qpsk_symbol_mod.sv
// Self-checking bench for qpsk_symbol_mod: directed test-plan steps plus a
// randomized stretch, all compared against a symbol-level reference model.
module tb_qpsk_symbol_mod;

    localparam int DW  = 8;
    localparam int SPS = 30;
    localparam int CW  = 8;

    logic clk;
    logic rst_n;

    qpsk_symbol_mod_if #(.DW(DW)) qbus ();

    qpsk_symbol_mod #(.DW(DW), .SPS(SPS), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (qbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: bits collected so far, samples into the symbol, active symbol.
    int m_nbits;
    bit m_i, m_q;
    int m_cnt;
    bit m_act, m_ai, m_aq;
    int m_data;
    bit m_valid, m_und;

    bit bitq[$];

    int obs_first_data;
    int obs_first_und;
    int obs_first_act;
    int obs_und_cnt;

    function automatic int sgn(bit b);
        return b ? -1 : 1;
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_nbits = 0; m_i = 1'b0; m_q = 1'b0; m_cnt = 0;
        m_act = 1'b0; m_ai = 1'b0; m_aq = 1'b0;
        m_data = 0; m_valid = 1'b0; m_und = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid", qbus.out_valid, m_valid);
        chk("underrun", qbus.underrun, m_und);
        chk("sym_active", qbus.sym_active, m_act);
        chk("data_out", qbus.data_out, m_data);
    endtask

    // One clock: drive inputs, advance the model, compare outputs after the edge.
    task automatic step(bit smp, int s, int c, bit bv, bit b, output bit xfer);
        bit ready_m;
        qbus.smp_valid = smp;
        qbus.sin_in    = s[DW-1:0];
        qbus.cos_in    = c[DW-1:0];
        qbus.bit_valid = bv;
        qbus.bit_in    = b;
        ready_m = (m_nbits < 2);
        chk("bit_ready", qbus.bit_ready, ready_m);
        xfer = bv && ready_m;
        @(posedge clk);
        #1;
        if (smp) begin
            if (m_cnt == 0) begin
                if (m_nbits == 2) begin
                    m_act = 1'b1; m_ai = m_i; m_aq = m_q; m_nbits = 0; m_und = 1'b0;
                end else begin
                    m_act = 1'b0; m_und = 1'b1;
                end
            end else begin
                m_und = 1'b0;
            end
            m_data  = m_act ? (sgn(m_ai) * c + sgn(m_aq) * s) : 0;
            m_cnt   = (m_cnt + 1) % SPS;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
            m_und   = 1'b0;
        end
        if (xfer) begin
            if (m_nbits == 0) m_i = b;
            else              m_q = b;
            m_nbits++;
        end
        check_outputs();
        if (qbus.underrun === 1'b1) obs_und_cnt++;
    endtask

    // n cycles (samples or idle), offering queued bits as the collector accepts them.
    task automatic run(int n, bit smp, int s, int c);
        bit xf;
        bit bv, b;
        for (int k = 0; k < n; k++) begin
            bv = (bitq.size() > 0);
            b  = bv ? bitq[0] : 1'b0;
            step(smp, s, c, bv, b, xf);
            if (xf) void'(bitq.pop_front());
            if (k == 0) begin
                obs_first_data = int'(qbus.data_out);
                obs_first_und  = int'(qbus.underrun);
                obs_first_act  = int'(qbus.sym_active);
            end
        end
    endtask

    task automatic do_reset();
        qbus.smp_valid = 1'b0; qbus.sin_in = '0; qbus.cos_in = '0;
        qbus.bit_valid = 1'b0; qbus.bit_in = 1'b0;
        rst_n = 1'b0;
        bitq.delete();
        model_reset();
        #3;
        check_outputs();
        chk("reset_bit_ready", qbus.bit_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit xf;
        int rs, rc;
        obs_und_cnt = 0;
        rst_n = 1'b1;
        #2;
        do_reset();

        // Dibit 0,0 presented before the first sample.
        bitq.push_back(1'b0); bitq.push_back(1'b0);
        run(3, 1'b0, 0, 0);
        bitq.push_back(1'b1); bitq.push_back(1'b1);
        run(SPS, 1'b1, 16, 77);
        chk("tp_first_93", obs_first_data, 93);
        chk("tp_first_active", obs_first_act, 1);

        bitq.push_back(1'b1); bitq.push_back(1'b0);
        run(SPS, 1'b1, -16, -77);
        chk("tp_11_pos93", obs_first_data, 93);
        run(SPS, 1'b1, 31, 74);
        chk("tp_10_neg43", obs_first_data, -43);

        // No bits: two idle symbols, one underrun each.
        obs_und_cnt = 0;
        run(2 * SPS, 1'b1, 5, 9);
        chk("underrun_count", obs_und_cnt, 2);

        // Extremes.
        bitq.push_back(1'b1); bitq.push_back(1'b1);
        run(3, 1'b0, 0, 0);
        bitq.push_back(1'b0); bitq.push_back(1'b0);
        run(SPS, 1'b1, -128, -128);
        chk("ext_pos256", obs_first_data, 256);
        run(SPS, 1'b1, -128, -128);
        chk("ext_neg256", obs_first_data, -256);

        // Second bit lands on the boundary cycle: idle now, applied one symbol later.
        bitq.push_back(1'b0);
        run(2, 1'b0, 0, 0);
        bitq.push_back(1'b1);
        run(SPS, 1'b1, 20, 50);
        chk("same_cycle_und", obs_first_und, 1);
        chk("same_cycle_idle", obs_first_data, 0);
        run(SPS, 1'b1, 20, 50);
        chk("same_cycle_later", obs_first_data, 30);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rs = int'($urandom_range(0, 255)) - 128;
            rc = int'($urandom_range(0, 255)) - 128;
            step($urandom_range(0, 3) != 0, rs, rc, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, xf);
        end

        // Async reset mid-symbol while collecting Q.
        do_reset();
        bitq.push_back(1'b0); bitq.push_back(1'b0);
        run(3, 1'b0, 0, 0);
        bitq.push_back(1'b1);
        run(12, 1'b1, 40, 60);
        chk("pre_reset_100", obs_first_data, 100);
        #2;
        rst_n = 1'b0;
        bitq.delete();
        model_reset();
        #1;
        check_outputs();
        chk("mid_reset_bit_ready", qbus.bit_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bitq.push_back(1'b0);
        run(1, 1'b1, 40, 60);
        chk("post_reset_und", obs_first_und, 1);
        run(SPS - 1, 1'b1, 40, 60);
        run(1, 1'b1, 40, 60);
        chk("old_i_gone", obs_first_act, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_qpsk_symbol_mod
